// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the serial transmitter: write-to-TX_START latency 2 cycles when idle.
// Writes never stall; a write into a full FIFO is dropped and flagged sticky in overflow.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2  = 4,
    parameter int TIMEOUT_CYC = 8192
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  tx_busy,
    input  logic                  tx_done,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  to_err
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [DEPTH_LOG2:0]   COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t                state;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [TIMER_W-1:0]    timer;
    logic [DEPTH_LOG2:0]   count_nxt;
    logic                  wr_accept;
    logic                  issue;

    // full/empty are the registered flags, so neither a same-cycle read nor
    // a same-cycle write is ever bypassed.
    assign wr_accept = wr_en && !full;
    assign issue     = (state == ST_IDLE) && !empty && !tx_busy;

    always_comb begin
        count_nxt = count;
        if (wr_accept && !issue) begin
            count_nxt = count + COUNT_ONE;
        end else if (!wr_accept && issue) begin
            count_nxt = count - COUNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == COUNT_FULL);
        end
    end

    // The issue is taken on the IDLE exit edge so TX_START is registered and
    // lands one cycle after the decision; the timer then runs from the
    // TX_START cycle, so a time-out is flagged TIMEOUT_CYC cycles after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rd_ptr   <= '0;
            timer    <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            to_err   <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        tx_data  <= mem[rd_ptr];
                        tx_start <= 1'b1;
                        rd_ptr   <= rd_ptr + PTR_ONE;
                        timer    <= '0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        state <= ST_IDLE;
                    end else if (timer == TIMER_LAST) begin
                        to_err <= 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and random bench for uart_tx_fifo against a queue-based reference model.
module tb_uart_tx_fifo;

    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int TO    = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [DL:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       to_err;

    uart_tx_fifo #(.DEPTH_LOG2(DL), .TIMEOUT_CYC(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .to_err   (to_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: queued bytes plus the transmit handshake state.
    logic [7:0] q [$];
    bit         m_wait  = 1'b0;
    bit         m_start = 1'b0;
    bit         m_ovf   = 1'b0;
    bit         m_to    = 1'b0;
    logic [7:0] m_data  = 8'h00;
    int         m_issue_cyc = 0;

    // Emulated serial transmitter: busy from TX_START, TX_DONE lat cycles later.
    int         xmit_left = 0;
    int         lat = 10;
    logic [7:0] start_log [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: emulated transmitter, 1: busy forced high, 2: dead transmitter
    task automatic tick(input bit r, input bit we, input logic [7:0] wd,
                        input int mode, input bit xdone);
        bit busy_d;
        bit done_d;
        int pre;
        busy_d  = (mode == 1) || (mode == 0 && xmit_left > 0);
        done_d  = xdone || (mode == 0 && xmit_left == 1);
        rst     = r;
        wr_en   = we;
        wr_data = wd;
        tx_busy = busy_d;
        tx_done = done_d;
        @(posedge clk);
        m_start = 1'b0;
        if (r) begin
            q.delete();
            m_wait = 1'b0;
            m_ovf  = 1'b0;
            m_to   = 1'b0;
            m_data = 8'h00;
        end else begin
            pre = q.size();
            if (!m_wait && pre != 0 && !busy_d) begin
                m_data      = q.pop_front();
                m_start     = 1'b1;
                m_wait      = 1'b1;
                m_issue_cyc = cyc + 1;
            end else if (m_wait) begin
                if (done_d) begin
                    m_wait = 1'b0;
                end else if (cyc - m_issue_cyc == TO - 1) begin
                    m_to   = 1'b1;
                    m_wait = 1'b0;
                end
            end
            if (we) begin
                if (pre == DEPTH) m_ovf = 1'b1;
                else q.push_back(wd);
            end
        end
        cyc++;
        #1;
        chk("tx_start", 32'(tx_start), 32'(m_start));
        chk("tx_data",  32'(tx_data),  32'(m_data));
        chk("count",    32'(count),    32'(q.size()));
        chk("empty",    32'(empty),    32'(q.size() == 0));
        chk("full",     32'(full),     32'(q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("to_err",   32'(to_err),   32'(m_to));
        if (xmit_left > 0) xmit_left--;
        if (tx_start === 1'b1) begin
            xmit_left = lat + 1;
            start_log.push_back(tx_data);
        end
    endtask

    initial begin
        int s_cyc;
        int t_cyc;
        logic [7:0] b;
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_busy = 1'b0; tx_done = 1'b0;

        repeat (3) tick(1, 0, 8'h00, 0, 0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_data",  32'(tx_data), 32'h00);

        // Single byte: COUNT 0,1,0 and TX_START two cycles after the write.
        lat = 20;
        tick(0, 1, 8'h55, 0, 0);
        chk("t1_count1", 32'(count), 32'd1);
        chk("t1_empty0", 32'(empty), 32'd0);
        tick(0, 0, 8'h00, 0, 0);
        chk("t1_start", 32'(tx_start), 32'd1);
        chk("t1_data",  32'(tx_data), 32'h55);
        chk("t1_count0", 32'(count), 32'd0);
        repeat (25) tick(0, 0, 8'h00, 0, 0);
        chk("t1_empty1", 32'(empty), 32'd1);

        // Back-to-back burst, transmitter answers 100 cycles after each start.
        lat = 100;
        start_log.delete();
        for (int i = 0; i < 5; i++) tick(0, 1, 8'(8'h10 + i), 0, 0);
        repeat (560) tick(0, 0, 8'h00, 0, 0);
        chk("t2_n", 32'(start_log.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk("t2_order", 32'(start_log[i]), 32'(8'h10 + i));

        // Fill while busy, overflow on the 17th, drain, then refill to wrap.
        xmit_left = 0;
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            tick(0, 1, b, 1, 0);
            if (i == 15) begin
                chk("t3_full", 32'(full), 32'd1);
                chk("t3_count16", 32'(count), 32'd16);
            end
        end
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_count_keep", 32'(count), 32'd16);
        lat = 3;
        start_log.delete();
        repeat (110) tick(0, 0, 8'h00, 0, 0);
        chk("t3_drained", 32'(start_log.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            tick(0, 1, b, 1, 0);
        end
        start_log.delete();
        repeat (110) tick(0, 0, 8'h00, 0, 0);
        chk("t3_drained2", 32'(start_log.size()), 32'd16);
        chk("t3_empty", 32'(empty), 32'd1);

        // Full FIFO with a write in the issue cycle: write dropped, COUNT=15.
        xmit_left = 0;
        tick(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 16; i++) tick(0, 1, 8'(8'h80 + i), 1, 0);
        chk("t4_full", 32'(full), 32'd1);
        chk("t4_ovf0", 32'(overflow), 32'd0);
        tick(0, 1, 8'hEE, 0, 0);
        chk("t4_count15", 32'(count), 32'd15);
        chk("t4_ovf1", 32'(overflow), 32'd1);
        chk("t4_start", 32'(tx_start), 32'd1);
        repeat (100) tick(0, 0, 8'h00, 0, 0);
        chk("t4_empty", 32'(empty), 32'd1);

        // Dead transmitter: TO_ERR exactly TO cycles after TX_START.
        xmit_left = 0;
        tick(1, 0, 8'h00, 0, 0);
        start_log.delete();
        tick(0, 1, 8'hA1, 2, 0);
        tick(0, 1, 8'hA2, 2, 0);
        s_cyc = -1;
        for (int k = 0; k < 10 && s_cyc < 0; k++) begin
            if (tx_start === 1'b1) s_cyc = cyc;
            else tick(0, 0, 8'h00, 2, 0);
        end
        chk("t5_start_seen", 32'(s_cyc >= 0), 32'd1);
        t_cyc = -1;
        for (int k = 0; k < 200 && t_cyc < 0; k++) begin
            tick(0, 0, 8'h00, 2, 0);
            if (to_err === 1'b1) t_cyc = cyc;
        end
        chk("t5_to_delay", 32'(t_cyc - s_cyc), 32'd64);
        repeat (5) tick(0, 0, 8'h00, 2, 0);
        chk("t5_next_n", 32'(start_log.size()), 32'd2);
        chk("t5_next_data", 32'(start_log[1]), 32'hA2);
        repeat (80) tick(0, 0, 8'h00, 2, 0);

        // Reset mid-transfer with 3 queued; the late TX_DONE must be ignored.
        xmit_left = 0;
        tick(1, 0, 8'h00, 0, 0);
        lat = 50;
        start_log.delete();
        for (int i = 0; i < 4; i++) tick(0, 1, 8'(8'h31 + i), 0, 0);
        repeat (3) tick(0, 0, 8'h00, 0, 0);
        chk("t6_count3", 32'(count), 32'd3);
        tick(1, 0, 8'h00, 0, 0);
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_empty", 32'(empty), 32'd1);
        chk("t6_rst_start", 32'(tx_start), 32'd0);
        chk("t6_rst_data",  32'(tx_data), 32'h00);
        repeat (60) tick(0, 0, 8'h00, 0, 0);
        chk("t6_no_start", 32'(start_log.size()), 32'd1);
        tick(0, 1, 8'h77, 0, 0);
        repeat (5) tick(0, 0, 8'h00, 0, 0);
        chk("t6_new_n", 32'(start_log.size()), 32'd2);
        chk("t6_new_data", 32'(start_log[1]), 32'h77);

        // Random traffic with occasional stalls and lost TX_DONE pulses.
        xmit_left = 0;
        tick(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            int r;
            int mode;
            bit we;
            r    = int'($urandom_range(0, 99));
            mode = (r < 5) ? 1 : ((r < 8) ? 2 : 0);
            we   = ($urandom_range(0, 99) < 40);
            lat  = int'($urandom_range(1, 12));
            tick(0, we, 8'($urandom), mode, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
